// File: rtl/mpsub_cond_if.sv
// Start/done handshake and operand/result bus between the Montgomery controller
// and the final conditional subtractor.
interface mpsub_cond_if #(
  parameter int WIDTH  = 1028,
  parameter int MWIDTH = 1027
) ();
  logic              start;
  logic [WIDTH-1:0]  in_a;
  logic [MWIDTH-1:0] in_m;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              borrow_out;

  modport master (
    output start, in_a, in_m,
    input  busy, done, result, borrow_out
  );

  modport slave (
    input  start, in_a, in_m,
    output busy, done, result, borrow_out
  );
endinterface

// File: rtl/mpsub_cond.sv
// Two-stage borrow-select conditional subtractor: result = (A >= M) ? A - M : A.
// Stage 1 precomputes both borrow-in candidates per limb, stage 2 ripples the select.
module mpsub_cond #(
  parameter int WIDTH  = 1028,
  parameter int LIMB   = 64,
  parameter int MWIDTH = 1027
) (
  input logic         clk,
  input logic         rst,
  mpsub_cond_if.slave bus
);
  localparam int NLIMB = WIDTH / LIMB;
  localparam int TOPW  = WIDTH - (NLIMB - 1) * LIMB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opm;
  logic [WIDTH-1:0] r_opa_byp;
  logic [WIDTH-1:0] r_result;
  logic             r_borrow;
  logic [WIDTH-1:0] w_diff;
  logic [NLIMB:0]   w_bin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_SEL;
      S_SEL:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.result     = r_result;
  assign bus.borrow_out = r_borrow;

  // Operands are only captured on an accepting edge; in_a/in_m may change afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa <= '0;
      r_opm <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_opa <= bus.in_a;
      r_opm <= WIDTH'(bus.in_m);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa_byp <= '0;
    end else if (r_state == S_LOAD) begin
      r_opa_byp <= r_opa;
    end
  end

  assign w_bin[0] = 1'b0;

  for (genvar gi = 0; gi < NLIMB; gi++) begin : g_limb
    localparam int LO = gi * LIMB;
    localparam int W  = (gi == NLIMB - 1) ? TOPW : LIMB;

    logic [W:0]   w_sub0;
    logic [W-1:0] r_d0;
    logic         r_b0;

    // One extra MSB so the top bit of the difference is the limb borrow.
    assign w_sub0 = {1'b0, r_opa[LO +: W]} - {1'b0, r_opm[LO +: W]};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_d0 <= '0;
        r_b0 <= 1'b0;
      end else if (r_state == S_LOAD) begin
        r_d0 <= w_sub0[W-1:0];
        r_b0 <= w_sub0[W];
      end
    end

    if (gi == 0) begin : g_first
      assign w_diff[LO +: W] = r_d0;
      assign w_bin[gi+1]     = r_b0;
    end else begin : g_sel
      logic [W:0]   w_sub1;
      logic [W-1:0] r_d1;
      logic         r_b1;

      assign w_sub1 = {1'b0, r_opa[LO +: W]} - {1'b0, r_opm[LO +: W]} - {{W{1'b0}}, 1'b1};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_d1 <= '0;
          r_b1 <= 1'b0;
        end else if (r_state == S_LOAD) begin
          r_d1 <= w_sub1[W-1:0];
          r_b1 <= w_sub1[W];
        end
      end

      assign w_diff[LO +: W] = w_bin[gi] ? r_d1 : r_d0;
      assign w_bin[gi+1]     = w_bin[gi] ? r_b1 : r_b0;
    end
  end

  // Final borrow set means A < M, so the untouched minuend is returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_borrow <= 1'b0;
    end else if (r_state == S_SEL) begin
      r_result <= w_bin[NLIMB] ? r_opa_byp : w_diff;
      r_borrow <= w_bin[NLIMB];
    end
  end

endmodule
